pipe_mdu_ctrl: RTL and testbench

- Sequencer for a shared iterative multiply/divide unit and the HI/LO register pair in the 5-stage pipeline.
- Decode issues mult/multu/div/divu, mfhi/mflo and mthi/mtlo requests.
- The block runs a 32-iteration shift-add multiply or restoring divide.
- It raises a stall (same role as wpcir) whenever decode touches the unit while it is busy.

---
 rtl/pipe_mdu_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipe_mdu_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mdu_ctrl.sv
// Iterative 32-cycle multiply/divide sequencer with HI/LO registers and decode stall.
// Optional divide-by-zero flag output enabled by defining MDU_DIVZ_FLAG_EN.
module pipe_mdu_ctrl #(
    parameter int ITER = 32
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        rd_req,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
`ifdef MDU_DIVZ_FLAG_EN
    ,
    output logic        divz
`endif
);

    // state | meaning
    // IDLE  | waiting for start; mthi/mtlo accepted
    // RUN   | one shift-add / shift-subtract iteration per edge
    // FIX   | sign correction and HI/LO write-back
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t      state, state_d;
    logic [1:0]  op_q;
    logic        sa, sb;
    logic [4:0]  iter_cnt;
    logic [63:0] acc;
    logic [31:0] opb;
    logic [31:0] hi_q, lo_q;
    logic        done_q;

    logic        signed_op;
    logic [31:0] abs_a, abs_b;
    logic [32:0] mul_sum;
    logic [64:0] div_shift;
    logic [32:0] div_trial;
    logic [63:0] acc_step;
    logic [63:0] prod_fix;
    logic [31:0] res_hi, res_lo;

    assign signed_op = op[0];
    assign abs_a     = (signed_op && a[31]) ? -a : a;
    assign abs_b     = (signed_op && b[31]) ? -b : b;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
        div_shift = {acc, 1'b0};
        div_trial = div_shift[64:32] - {1'b0, opb};
        if (op_q[1]) begin
            acc_step = div_trial[32] ? div_shift[63:0]
                                     : {div_trial[31:0], div_shift[31:1], 1'b1};
        end else begin
            acc_step = {mul_sum, acc[31:1]};
        end
    end

    always_comb begin
        prod_fix = (sa ^ sb) ? -acc : acc;
        if (op_q[1]) begin
            res_lo = (sa ^ sb) ? -acc[31:0] : acc[31:0];
            res_hi = sa ? -acc[63:32] : acc[63:32];
        end else begin
            res_lo = prod_fix[31:0];
            res_hi = prod_fix[63:32];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN:  if (iter_cnt == 5'(ITER - 1)) state_d = S_FIX;
            S_FIX:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            op_q     <= 2'b00;
            sa       <= 1'b0;
            sb       <= 1'b0;
            iter_cnt <= 5'd0;
            acc      <= 64'd0;
            opb      <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state == S_FIX);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        sa       <= signed_op & a[31];
                        sb       <= signed_op & b[31];
                        acc      <= {32'd0, abs_a};
                        opb      <= abs_b;
                        iter_cnt <= 5'd0;
                    end else begin
                        if (wr_hi) hi_q <= wdata;
                        if (wr_lo) lo_q <= wdata;
                    end
                end
                S_RUN: begin
                    acc      <= acc_step;
                    iter_cnt <= iter_cnt + 5'd1;
                end
                S_FIX: begin
                    hi_q <= res_hi;
                    lo_q <= res_lo;
                end
                default: ;
            endcase
        end
    end

`ifdef MDU_DIVZ_FLAG_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            divz <= 1'b0;
        end else if (state == S_IDLE && start) begin
            divz <= op[1] && (b == 32'd0);
        end
    end
`endif

    assign busy  = (state != S_IDLE);
    assign stall = busy & (start | rd_req | wr_hi | wr_lo);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_pipe_mdu_ctrl.sv
// Self-checking bench for pipe_mdu_ctrl: vector table, random ops against an arithmetic model,
// and hand sequences for stall, HI/LO writes and mid-operation reset (MDU_DIVZ_FLAG_EN aware).
module tb_pipe_mdu_ctrl;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        rd_req = 1'b0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        busy, stall, done;
    logic [31:0] hi, lo;
`ifdef MDU_DIVZ_FLAG_EN
    logic        divz;
`endif

    pipe_mdu_ctrl dut (
        .clock  (clock),
        .resetn (resetn),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .rd_req (rd_req),
        .wr_hi  (wr_hi),
        .wr_lo  (wr_lo),
        .wdata  (wdata),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
`ifdef MDU_DIVZ_FLAG_EN
        ,
        .divz   (divz)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic with the divide-by-zero rules applied explicitly.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x,
                                              input logic [31:0] y);
        longint sx, sy, q, r;
        longint unsigned ux, uy, p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'(x);
        uy = longint'(y);
        case (o)
            2'b00: begin
                p = ux * uy;
                return p;
            end
            2'b01: begin
                q = sx * sy;
                return q;
            end
            2'b10: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                p = ux / uy;
                ux = ux % uy;
                return {ux[31:0], p[31:0]};
            end
            default: begin
                if (sy == 0) begin
                    q = (sx >= 0) ? -1 : 1;
                    r = sx;
                end else begin
                    q = sx / sy;
                    r = sx % sy;
                end
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] exp_hilo, input bit with_wr, input string nm);
        int  busy_cycles;
        bit  early_done;
        @(negedge clock);
        start = 1'b1; op = o; a = x; b = y;
        wr_lo = with_wr; wdata = $urandom;
        #1;
        chk({nm, " idle_busy"}, {63'd0, busy}, 64'd0);
        @(negedge clock);
        start = 1'b0; wr_lo = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
        busy_cycles = 0;
        early_done = 0;
        while (busy && busy_cycles < 60) begin
            if (done) early_done = 1;
            busy_cycles++;
            @(negedge clock);
        end
        chk({nm, " busy_cycles"}, 64'(busy_cycles), 64'd33);
        chk({nm, " early_done"}, {63'd0, early_done}, 64'd0);
        chk({nm, " done_pulse"}, {63'd0, done}, 64'd1);
        chk({nm, " hi"}, {32'd0, hi}, {32'd0, exp_hilo[63:32]});
        chk({nm, " lo"}, {32'd0, lo}, {32'd0, exp_hilo[31:0]});
`ifdef MDU_DIVZ_FLAG_EN
        chk({nm, " divz"}, {63'd0, divz}, {63'd0, o[1] && (y == 32'd0)});
`endif
        @(negedge clock);
        chk({nm, " done_clear"}, {63'd0, done}, 64'd0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [1:0]  ro;
        logic [31:0] rx, ry, hi_before;
        bit          exp_stall;
        vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{2'b01, 32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFFF, 32'hFFFF_FFD6};
        vecs[2]  = '{2'b11, 32'hFFFF_FFEF, 32'd5,         32'hFFFF_FFFE, 32'hFFFF_FFFD};
        vecs[3]  = '{2'b10, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[4]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        vecs[5]  = '{2'b10, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
        vecs[6]  = '{2'b11, 32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 32'h0000_0001};
        vecs[7]  = '{2'b11, 32'd9,         32'd0,         32'd9,         32'hFFFF_FFFF};
        vecs[8]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
        vecs[9]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1};
        vecs[10] = '{2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};

        #12;
        chk("rst busy", {63'd0, busy}, 64'd0);
        chk("rst done", {63'd0, done}, 64'd0);
        chk("rst hi", {32'd0, hi}, 64'd0);
        chk("rst lo", {32'd0, lo}, 64'd0);
`ifdef MDU_DIVZ_FLAG_EN
        chk("rst divz", {63'd0, divz}, 64'd0);
`endif
        @(negedge clock);
        resetn = 1'b1;

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].exp_hi, vecs[i].exp_lo}, 0,
                   $sformatf("vec%0d", i));

        for (int i = 0; i < 12; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
            case ($urandom_range(0, 4))
                0:       ry = 32'd0;
                1:       ry = 32'($urandom_range(1, 20));
                2:       ry = -32'($urandom_range(1, 20));
                default: ry = $urandom;
            endcase
            run_op(ro, rx, ry, ref_model(ro, rx, ry), 0, $sformatf("rnd%0d", i));
        end

        // Stall sequence: divu with rd_req, a second start and an mthi during busy.
        hi_before = hi;
        @(negedge clock);
        start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd7;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clock);
            start = (k == 10); rd_req = (k == 5 || k == 33); wr_hi = (k == 12);
            op = (k == 10) ? 2'b00 : 2'b10; a = 32'd3; b = 32'd3; wdata = 32'hDEAD_BEEF;
            exp_stall = (k == 5 || k == 33 || k == 10 || k == 12);
            #1;
            chk($sformatf("stall_seq busy k%0d", k), {63'd0, busy}, 64'd1);
            if (exp_stall)
                chk($sformatf("stall_seq stall k%0d", k), {63'd0, stall}, 64'd1);
            if (k == 13 || k == 20)
                chk($sformatf("stall_seq hi_hold k%0d", k), {32'd0, hi}, {32'd0, hi_before});
        end
        @(negedge clock);
        start = 1'b0; wr_hi = 1'b0; rd_req = 1'b1;
        #1;
        chk("stall_seq busy_end", {63'd0, busy}, 64'd0);
        chk("stall_seq done", {63'd0, done}, 64'd1);
        chk("stall_seq stall_after", {63'd0, stall}, 64'd0);
        chk("stall_seq lo", {32'd0, lo}, 64'd142);
        chk("stall_seq hi", {32'd0, hi}, 64'd6);
        @(negedge clock);
        #1;
        chk("stall_seq busy_after2", {63'd0, busy}, 64'd0);
        chk("stall_seq stall_after2", {63'd0, stall}, 64'd0);
        rd_req = 1'b0;

        // HI/LO writes in IDLE; start wins over mtlo.
        @(negedge clock);
        wr_hi = 1'b1; wdata = 32'h1234_5678;
        @(negedge clock);
        wr_hi = 1'b0;
        chk("mthi hi", {32'd0, hi}, 64'h1234_5678);
        wr_lo = 1'b1; wdata = 32'hA5A5_0F0F;
        @(negedge clock);
        wr_lo = 1'b0;
        chk("mtlo lo", {32'd0, lo}, 64'hA5A5_0F0F);
        chk("mtlo hi_kept", {32'd0, hi}, 64'h1234_5678);
        rd_req = 1'b1;
        #1;
        chk("idle rd_req stall", {63'd0, stall}, 64'd0);
        rd_req = 1'b0;
        run_op(2'b00, 32'd1000, 32'd1000, 64'd1000000, 1, "start_wins");

        // Asynchronous reset in the middle of a divide.
        @(negedge clock);
        start = 1'b1; op = 2'b11; a = 32'hFFFF_0000; b = 32'd3;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        #2;
        resetn = 1'b0;
        #1;
        chk("midrst busy", {63'd0, busy}, 64'd0);
        chk("midrst hi", {32'd0, hi}, 64'd0);
        chk("midrst lo", {32'd0, lo}, 64'd0);
        @(negedge clock);
        resetn = 1'b1;
        run_op(2'b10, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 0, "post_rst divu");
        run_op(2'b10, 32'd9, 32'd2, {32'd1, 32'd4}, 0, "divz_clear divu");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
